// File: rtl/fm_pkg.sv
// Shared types and constants for the FM modulator: IQ sample packing,
// phase width and the elaboration-time sine table generator.
package fm_pkg;

  localparam int IQ_W    = 16;
  localparam int PHASE_W = 32;

  // pi * 2^30, rounded; fixed-point scale used by the table generator
  localparam longint PI_Q30 = 64'sd3373259426;

  // Field order matches the bus: imag in [31:16], real in [15:0]
  typedef struct packed {
    logic signed [IQ_W-1:0] im;
    logic signed [IQ_W-1:0] re;
  } iq_t;

  // Entry i of a full-cycle table of depth 2^aw: round(32767*sin(2*pi*i/2^aw)).
  // Integer-only so it folds at elaboration; the first quadrant is evaluated by
  // a Q30 Taylor series and the other three come from symmetry, so the table is
  // exactly odd-symmetric and never reaches -32768.
  function automatic logic signed [IQ_W-1:0] sin_entry(input int i, input int aw);
    longint quarter, q, j, arg, x, x2, t, s, v;
    quarter = longint'(1) <<< (aw - 2);
    q       = longint'((i >>> (aw - 2)) & 3);
    j       = longint'(i) & (quarter - 64'sd1);
    arg     = q[0] ? (quarter - j) : j;
    if (arg == quarter) begin
      v = 64'sd32767;
    end else begin
      x  = (arg * PI_Q30) / (quarter <<< 1);
      x2 = (x * x) >>> 30;
      t  = x;
      s  = x;
      for (int k = 1; k <= 10; k++) begin
        t = -((t * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
        s = s + t;
      end
      v = (s * 64'sd32767 + 64'sd536870912) >>> 30;
    end
    if (q[1]) v = -v;
    return $signed(v[IQ_W-1:0]);
  endfunction

endpackage

// File: rtl/fm_sincos_rom.sv
// Dual-read synchronous sine/cosine ROM. Cosine is read from the same sine
// table a quarter turn ahead. One-cycle latency; outputs hold when en=0.
module fm_sincos_rom
  import fm_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic [ADDR_W-1:0]      addr,
  output logic signed [IQ_W-1:0] sin,
  output logic signed [IQ_W-1:0] cos
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] QTR = ADDR_W'(DEPTH / 4);

  logic signed [IQ_W-1:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom[g] = sin_entry(g, ADDR_W);
  end

  // Registered reads; the cosine address wraps naturally at ADDR_W bits
  always_ff @(posedge clk) begin
    if (en) begin
      sin <= rom[addr];
      cos <= rom[addr + QTR];
    end
  end

endmodule

// File: rtl/fm_mod64.sv
// Differential-phase FM modulator: integrates signed phase increments and
// emits unit-amplitude {imag, real} samples over AXI-Stream.
// Three register stages (accumulate, ROM, scale) share one enable, so the
// whole pipeline stalls together under output backpressure.
// Optional build macro FM_MOD_PHASE_RESET_ON_TLAST_EN: clear the phase
// accumulator after each beat carrying tlast.
module fm_mod64
  import fm_pkg::*;
#(
  parameter int                 C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int                 C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int                 LUT_ADDR_W             = 10,
  parameter logic [PHASE_W-1:0] CENTER_FREQ            = 32'h0000_0000,
  parameter int                 AMP_SHIFT              = 0
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  s00_axis_tvalid,
  output logic                                  s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
  input  logic                                  s00_axis_tlast,
  output logic                                  m00_axis_tvalid,
  input  logic                                  m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
  output logic                                  m00_axis_tlast
);

  localparam int STAGES = 3;

  logic                         en, accept;
  logic [PHASE_W-1:0]           phase_acc, phase_nxt;
  logic [LUT_ADDR_W-1:0]        addr1;
  logic [STAGES:1]              vld_pipe, last_pipe;
  logic signed [IQ_W-1:0]       rom_sin, rom_cos;
  iq_t                          iq_out;
  logic                         unused_tstrb;

  assign unused_tstrb    = ^s00_axis_tstrb;

  assign en              = m00_axis_tready || !m00_axis_tvalid;
  assign s00_axis_tready = s00_axis_aresetn && en;
  assign accept          = s00_axis_tvalid && s00_axis_tready;
  assign phase_nxt       = phase_acc + CENTER_FREQ + PHASE_W'(s00_axis_tdata);

  // Stage 1: integrate accepted increments; only the LUT address bits of the
  // updated phase are carried forward since the rest never reach the ROM
  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      phase_acc <= '0;
      addr1     <= '0;
    end else if (accept) begin
      addr1     <= phase_nxt[PHASE_W-1 -: LUT_ADDR_W];
`ifdef FM_MOD_PHASE_RESET_ON_TLAST_EN
      phase_acc <= s00_axis_tlast ? '0 : phase_nxt;
`else
      phase_acc <= phase_nxt;
`endif
    end
  end

  // Valid and tlast travel together down the pipe, advancing only on en
  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else if (en) begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], accept};
      last_pipe <= {last_pipe[STAGES-1:1], accept && s00_axis_tlast};
    end
  end

  // Stage 2: registered sine/cosine lookup
  fm_sincos_rom #(.ADDR_W(LUT_ADDR_W)) u_rom (
    .clk  (s00_axis_aclk),
    .en   (en),
    .addr (addr1),
    .sin  (rom_sin),
    .cos  (rom_cos)
  );

  // Stage 3: amplitude scaling into the output register
  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      iq_out <= '0;
    end else if (en) begin
      iq_out.im <= rom_sin >>> AMP_SHIFT;
      iq_out.re <= rom_cos >>> AMP_SHIFT;
    end
  end

  assign m00_axis_tvalid = vld_pipe[STAGES];
  assign m00_axis_tlast  = last_pipe[STAGES];
  assign m00_axis_tdata  = C_M00_AXIS_TDATA_WIDTH'(iq_out);
  assign m00_axis_tstrb  = '1;

endmodule

// File: tb/tb_fm_mod64.sv
// Self-checking bench for fm_mod64: directed quarter-turn and DC cases,
// randomized streams with random backpressure against a phase/trig model,
// reset-in-flight, tlast placement and a demodulator loopback phase check.
`timescale 1ns/1ps
module tb_fm_mod64;

  localparam real         PI = 3.14159265358979323846;
  localparam logic [31:0] CF = 32'h0000_0000;
`ifdef FM_MOD_PHASE_RESET_ON_TLAST_EN
  localparam bit TLAST_RST = 1'b1;
`else
  localparam bit TLAST_RST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tstrb = 4'hF;
  logic        m_tvalid, m_tready = 1'b0, m_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;

  always #5 clk = ~clk;

  fm_mod64 #(.CENTER_FREQ(CF), .AMP_SHIFT(0)) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tready  (s_tready),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tstrb   (s_tstrb),
    .s00_axis_tlast   (s_tlast),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tready  (m_tready),
    .m00_axis_tdata   (m_tdata),
    .m00_axis_tstrb   (m_tstrb),
    .m00_axis_tlast   (m_tlast)
  );

  int          checks = 0, errors = 0, cyc_n = 0, first_v = -1;
  logic [31:0] acc_ph = '0;
  logic [32:0] expq[$], got[$];
  logic [31:0] txd[$];
  logic        txl[$];
  logic        held_v = 1'b0;
  logic [32:0] held = '0;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] q15(input real x);
    int v;
    v = int'(32767.0 * x);
    return v[15:0];
  endfunction

  // Ideal sample for a phase: angle taken from the top 10 phase bits
  function automatic logic [31:0] iq_of(input logic [31:0] ph);
    real th;
    th = 2.0 * PI * real'(ph[31:22]) / 1024.0;
    return {q15($sin(th)), q15($cos(th))};
  endfunction

  // One clock: drive at negedge, check 1ns later, update model after posedge
  task automatic cyc(input logic v, input logic [31:0] d, input logic l,
                     input logic mr, output logic acc);
    logic [32:0] e;
    s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = mr;
    #1;
    if (held_v) begin
      chk("hold_valid", 33'(m_tvalid), 33'd1);
      chk("hold_beat", {m_tlast, m_tdata}, held);
    end
    chk("s_tready", 33'(s_tready), 33'(rst_n && (mr || !m_tvalid)));
    if (m_tvalid && first_v < 0) first_v = cyc_n;
    acc = v && s_tready;
    if (m_tvalid && mr) begin
      got.push_back({m_tlast, m_tdata});
      if (expq.size() == 0) chk("spurious_out", 33'(m_tvalid), 33'd0);
      else begin
        e = expq.pop_front();
        chk("out_beat", {m_tlast, m_tdata}, e);
      end
    end
    held_v = m_tvalid && !mr;
    held   = {m_tlast, m_tdata};
    @(posedge clk);
    if (acc) begin
      acc_ph = acc_ph + CF + d;
      expq.push_back({l, iq_of(acc_ph)});
      if (TLAST_RST && l) acc_ph = '0;
    end
    cyc_n++;
    @(negedge clk);
  endtask

  // Push txd/txl through with ready asserted rdy_pct% of cycles, then drain
  task automatic send(input int rdy_pct);
    int   i = 0, guard = 0;
    logic a;
    got.delete();
    while (i < txd.size() && guard < 2000) begin
      cyc(1'b1, txd[i], txl[i], $urandom_range(99) < rdy_pct, a);
      if (a) i++;
      guard++;
    end
    while (expq.size() != 0 && guard < 4000) begin
      cyc(1'b0, '0, 1'b0, $urandom_range(99) < rdy_pct, a);
      guard++;
    end
    chk("send_done", 33'(expq.size() == 0 && i == txd.size()), 33'd1);
  endtask

  task automatic load(input int n, input logic [31:0] d, input bit rnd);
    txd.delete(); txl.delete();
    for (int k = 0; k < n; k++) begin
      txd.push_back(rnd ? $urandom() : d);
      txl.push_back(1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic        a;
    int          c0;
    logic [31:0] q_exp [4];
    real         re0, im0, re1, im1, ang, rf, err;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_tvalid", 33'(m_tvalid), 33'd0);
    chk("rst_tdata", 33'(m_tdata), 33'd0);
    chk("rst_tlast", 33'(m_tlast), 33'd0);
    chk("rst_s_tready", 33'(s_tready), 33'd0);
    chk("tstrb", 33'(m_tstrb), 33'hF);
    @(negedge clk);
    rst_n = 1'b1;

    // DC: zero increments sit at phase 0; latency 3 and no bubbles
    load(4, 32'h0, 1'b0);
    c0 = cyc_n; first_v = -1;
    send(100);
    chk("latency", 33'(first_v - c0), 33'd3);
    chk("throughput", 33'(cyc_n - c0), 33'd7);
    for (int k = 0; k < 4; k++) chk("dc_out", got[k], 33'h0_0000_7FFF);

    // Quarter-turn rotation, accumulator wraps back to 0
    q_exp[0] = 32'h7FFF_0000; q_exp[1] = 32'h0000_8001;
    q_exp[2] = 32'h8001_0000; q_exp[3] = 32'h0000_7FFF;
    load(4, 32'h4000_0000, 1'b0);
    send(100);
    for (int k = 0; k < 4; k++) chk("quarter_out", got[k], {1'b0, q_exp[k]});

    // Backpressure: random tready, stability checked inside cyc
    load(8, 32'h1000_0000, 1'b0);
    send(50);
    chk("bp_count", 33'(got.size()), 33'd8);

    // tlast on beat 3 of 6
    load(6, 32'h0, 1'b1);
    txl[2] = 1'b1;
    send(70);
    for (int k = 0; k < 6; k++) chk("tlast_pos", 33'(got[k][32]), 33'(k == 2));

    // Reset with two beats in flight
    cyc(1'b1, 32'h1234_5678, 1'b0, 1'b1, a);
    cyc(1'b1, 32'h2345_6789, 1'b0, 1'b1, a);
    rst_n = 1'b0; s_tvalid = 1'b0;
    #1;
    chk("midrst_s_tready", 33'(s_tready), 33'd0);
    @(posedge clk);
    #1;
    chk("midrst_tvalid", 33'(m_tvalid), 33'd0);
    chk("midrst_tdata", 33'(m_tdata), 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expq.delete(); acc_ph = '0; held_v = 1'b0;
    for (int k = 0; k < 4; k++) cyc(1'b0, '0, 1'b0, 1'b1, a);
    load(3, 32'h0, 1'b1);
    send(100);
    chk("post_rst_first", got[0], {1'b0, iq_of(CF + txd[0])});

    // Loopback: demodulated phase difference recovers each increment
    txd.delete(); txl.delete();
    for (int k = 0; k < 40; k++) begin
      txd.push_back(32'($urandom_range(32'h4000_0000)) - 32'h2000_0000);
      txl.push_back(1'b0);
    end
    send(60);
    for (int k = 1; k < 40; k++) begin
      re0 = real'($signed(got[k-1][15:0])); im0 = real'($signed(got[k-1][31:16]));
      re1 = real'($signed(got[k][15:0]));   im1 = real'($signed(got[k][31:16]));
      ang = $atan2(im1 * re0 - re1 * im0, re1 * re0 + im1 * im0);
      rf  = 2.0 * PI * real'($signed(txd[k] + CF)) / 4294967296.0;
      err = (ang - rf) / (2.0 * PI / 1024.0);
      chk("demod_phase", 33'(err <= 1.01 && err >= -1.01), 33'd1);
    end

    // Fully random increments and packet boundaries under backpressure
    load(30, 32'h0, 1'b1);
    for (int k = 0; k < 30; k++) txl[k] = ($urandom_range(4) == 0);
    send(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fm_mod64.md
Name: fm_mod64

Overview:
- Differential-phase (FM) modulator; the transmit-side counterpart of the IQ differential demodulator.
- Accepts a stream of signed per-sample phase increments on an AXI-Stream slave.
- Integrates them in a 32-bit phase accumulator and emits unit-amplitude complex baseband samples on an AXI-Stream master.
- Output packing is {imag[31:16], real[15:0]}, which the demod consumes directly.

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 32, input word width; the phase increment is the full 32 bits, signed.
- C_M00_AXIS_TDATA_WIDTH, 32, output word width; {imag, real}, 16 bits each, signed.
- LUT_ADDR_W, 10, log2 of full-cycle sine ROM depth.
- CENTER_FREQ, 32'h0000_0000, constant phase increment added to every beat (carrier offset).
- AMP_SHIFT, 0, arithmetic right shift applied to both output components (0..15).

Ports:
- s00_axis_aclk  in  1  single clock
- s00_axis_aresetn  in  1  reset; synchronous, active-low
- s00_axis_tvalid  in  1  input beat valid
- s00_axis_tready  out  1  input accept
- s00_axis_tdata  in  32  signed phase increment delta (turns × 2^32)
- s00_axis_tstrb  in  4  ignored
- s00_axis_tlast  in  1  end of packet
- m00_axis_tvalid  out  1  output beat valid
- m00_axis_tready  in  1  downstream accept
- m00_axis_tdata  out  32  {imag[31:16], real[15:0]}, signed Q1.15
- m00_axis_tstrb  out  4  constant 4'hF
- m00_axis_tlast  out  1  tlast delayed in lockstep with data

Behaviour:
- Reset (aresetn low at a clock edge):
  - phase_acc=0; all stage valids=0.
  - m00_axis_tvalid=0, m00_axis_tdata=0, m00_axis_tlast=0.
  - Reset mid-packet discards every in-flight beat.
  - s00_axis_tready is 0 while reset is asserted.
- Pipeline control:
  - Pipeline enable en = m00_axis_tready || !m00_axis_tvalid.
  - s00_axis_tready = en (combinational, out of reset).
  - A beat is accepted when s00_axis_tvalid && s00_axis_tready.
  - When en=0, every stage holds, including tdata, tvalid and tlast.
  - Output is stable under backpressure, per AXIS rules.
- Stage 1 (on accept):
  - phase_acc <= phase_acc + CENTER_FREQ + delta, modulo 2^32 with silent wrap.
  - Register the new phase and the beat's tlast; v1 <= 1.
  - If en=1 with no input beat, v1 <= 0 and phase_acc holds.
- Stage 2: addr = phase[31 -: LUT_ADDR_W].
  - sin ROM read at addr; cos ROM read at addr + 2^(LUT_ADDR_W-2), mod depth.
  - Registered ROM output.
- Stage 3:
  - real = cos >>> AMP_SHIFT; imag = sin >>> AMP_SHIFT.
  - Drive m00_axis_tdata, tvalid and tlast.
- Latency: exactly 3 en-cycles from input accept to m00_axis_tvalid.
- Throughput: 1 beat/cycle with no bubbles while m00_axis_tready=1.
- ROM: entry i = round(32767·sin(2πi/2^LUT_ADDR_W)); no entry equals -32768.
- Phase definition: beat k outputs (cos, sin) of the accumulated phase after adding its own increment.
  - The demod's conj product of outputs k and k-1 therefore recovers delta_k + CENTER_FREQ.
- Simultaneous input accept and output drain in one cycle is the normal streaming case; no beat is lost or duplicated.

Optional Feature:
- Macro: FM_MOD_PHASE_RESET_ON_TLAST_EN.
- When defined: an accepted beat with tlast=1 still produces its own sample from the updated phase, then phase_acc <= 0. The next packet starts at phase 0 plus its first increment.
  - If reset and tlast coincide, reset wins.
- When undefined: phase is continuous across packets, and tlast is only passed through.

Decomposition:
- Package fm_pkg holds:
  - IQ_W=16 constant.
  - typedef iq_t {logic signed [15:0] imag; logic signed [15:0] real;}, packed to match the 32-bit bus order.
  - PHASE_W=32 constant.
  - ROM init function for the sine table.
- Sub-module fm_sincos_rom: dual-read synchronous ROM with inputs clk, en, addr and outputs sin, cos (one-cycle latency, holds when en=0).

Test Plan:
- Constant stream delta=0, CENTER_FREQ=0, m_tready=1, 4 beats -> 4 outputs 32'h0000_7FFF, the first 3 cycles after the first accept.
- delta=32'h4000_0000 ×4 -> outputs 32'h7FFF_0000, 32'h0000_8001, 32'h8001_0000, 32'h0000_7FFF (quarter-turn rotation; accumulator wraps to 0 on beat 4).
- Backpressure: stream 8 beats of delta=32'h1000_0000 while m_tready toggles randomly -> output sequence identical to the unthrottled run, tdata/tlast stable while tvalid && !tready, s_tready low only while stalled.
- tlast on beat 3 of 6 -> m00_axis_tlast high on exactly output 3. With FM_MOD_PHASE_RESET_ON_TLAST_EN, output 4 equals the output for phase=delta_4; without it, phase is continuous.
- Assert aresetn low for 1 cycle with 2 beats in flight -> next cycle m_tvalid=0, tdata=0; the next accepted beat uses phase_acc starting from 0.
- Loopback into the demod with AMP_SHIFT=0: random deltas in ±2^29 -> atan2 of the demod output matches the delta within 1 LUT LSB of phase.
